// File: rtl/fwd_hazard_tracker_if.sv
// EX-stage side of the forwarding/hazard tracker: operand addresses in,
// bypass selects, stall request and stall counter out.
interface fwd_hazard_tracker_if #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int SW      = 2,
    parameter int CW      = 16
);
    logic                   ex_valid;
    logic                   ex_regwrite;
    logic                   ex_is_load;
    logic [AW-1:0]          ex_rd;
    logic [NUM_SRC*AW-1:0]  ex_src;
    logic [NUM_SRC-1:0]     ex_src_used;
    logic                   flush;
    logic [NUM_SRC*SW-1:0]  fwd_sel;
    logic [NUM_SRC-1:0]     fwd_hit;
    logic                   stall_req;
    logic [CW-1:0]          stall_cnt;

    modport master (
        output ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_src, ex_src_used, flush,
        input  fwd_sel, fwd_hit, stall_req, stall_cnt
    );

    modport slave (
        input  ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_src, ex_src_used, flush,
        output fwd_sel, fwd_hit, stall_req, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// Forwarding and load-use hazard tracker. Keeps a private shift register of
// in-flight destination writes (stage 1 = EX/MEM .. DEPTH), selects the
// youngest producer for each EX source operand, and requests a one-cycle
// stall when the winning producer is a load still in stage 1.
module fwd_hazard_tracker #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int DEPTH   = 3,
    parameter int SW      = 2,
    parameter int CW      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_tracker_if.slave bus
);

    logic [DEPTH:1]        v_q;
    logic [DEPTH:1]        wr_q;
    logic [DEPTH:1]        ld_q;
    logic [AW-1:0]         rd_q [1:DEPTH];
    logic [DEPTH:1]        live;
    logic [NUM_SRC*SW-1:0] sel;
    logic [NUM_SRC-1:0]    hit;
    logic                  stall;
    logic [CW-1:0]         cnt_q;

    // An entry can forward only if it really writes a non-zero register.
    always_comb begin
        live = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            live[k] = v_q[k] & wr_q[k] & (rd_q[k] != '0);
        end
    end

    // Per-operand youngest-match search and load-use detection.
    always_comb begin
        sel   = '0;
        hit   = '0;
        stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [SW-1:0] win;
            logic          found;
            win   = '0;
            found = 1'b0;
            if (bus.ex_valid && bus.ex_src_used[i]) begin
                // Walk oldest to youngest so the youngest match is the last write.
                for (int k = DEPTH; k >= 1; k--) begin
                    if (live[k] && (rd_q[k] == bus.ex_src[i*AW +: AW])) begin
                        win   = SW'(k);
                        found = 1'b1;
                    end
                end
            end
            sel[i*SW +: SW] = win;
            hit[i]          = found;
            if (found && (win == SW'(1)) && ld_q[1]) begin
                stall = 1'b1;
            end
        end
    end

    // Advance the in-flight write pipeline; stall, flush or idle inserts a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q  <= '0;
            wr_q <= '0;
            ld_q <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                v_q[k]  <= v_q[k-1];
                wr_q[k] <= wr_q[k-1];
                ld_q[k] <= ld_q[k-1];
                rd_q[k] <= rd_q[k-1];
            end
            if (stall || bus.flush || !bus.ex_valid) begin
                v_q[1]  <= 1'b0;
                wr_q[1] <= 1'b0;
                ld_q[1] <= 1'b0;
                rd_q[1] <= '0;
            end else begin
                v_q[1]  <= 1'b1;
                wr_q[1] <= bus.ex_regwrite;
                ld_q[1] <= bus.ex_is_load;
                rd_q[1] <= bus.ex_rd;
            end
        end
    end

    // Saturating count of stall cycles for performance monitoring.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.fwd_sel   = sel;
    assign bus.fwd_hit   = hit;
    assign bus.stall_req = stall;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed bench for fwd_hazard_tracker: a vector table walked one cycle per
// entry (pipeline state carries between rows), then counter saturation and
// reset-during-stall sequences.
module tb_fwd_hazard_tracker;

    localparam int NUM_SRC = 2;
    localparam int AW      = 5;
    localparam int SW      = 2;
    localparam int CW      = 4;
    localparam int NVEC    = 31;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_tracker_if #(.NUM_SRC(NUM_SRC), .AW(AW), .SW(SW), .CW(CW)) bus ();

    fwd_hazard_tracker #(.NUM_SRC(NUM_SRC), .AW(AW), .DEPTH(3), .SW(SW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       v;
        logic       w;
        logic       l;
        logic [4:0] rd;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic       fl;
        logic [1:0] e_sel0;
        logic [1:0] e_sel1;
        logic [1:0] e_hit;
        logic       e_stall;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic v, input logic w, input logic l, input int rd,
                                input int s0, input int s1, input logic [1:0] used,
                                input logic fl, input int e0, input int e1,
                                input logic [1:0] eh, input logic es, input int ec);
        vec_t t;
        t.v = v; t.w = w; t.l = l; t.rd = 5'(rd); t.s0 = 5'(s0); t.s1 = 5'(s1);
        t.used = used; t.fl = fl; t.e_sel0 = 2'(e0); t.e_sel1 = 2'(e1);
        t.e_hit = eh; t.e_stall = es; t.e_cnt = 4'(ec);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic l, input logic [4:0] rd,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic fl);
        bus.ex_valid    = v;
        bus.ex_regwrite = w;
        bus.ex_is_load  = l;
        bus.ex_rd       = rd;
        bus.ex_src      = {s1, s0};
        bus.ex_src_used = used;
        bus.flush       = fl;
    endtask

    initial begin
        int         nstall;
        logic       e1_ld;
        logic [3:0] exp_cnt;

        // Row order matters: each row sees the pipeline left by the rows before it.
        tbl[0]  = mk(1,1,0, 3,  1, 2, 2'b11,0, 0,0,2'b00,0,0); // add r3
        tbl[1]  = mk(1,1,0,10,  3, 4, 2'b11,0, 1,0,2'b01,0,0); // back-to-back consumer
        tbl[2]  = mk(1,1,0, 5,  0, 0, 2'b00,0, 0,0,2'b00,0,0);
        tbl[3]  = mk(1,1,0, 5,  3,10, 2'b11,0, 3,2,2'b11,0,0); // r3@3, r10@2
        tbl[4]  = mk(1,0,0, 5,  5, 0, 2'b01,0, 1,0,2'b01,0,0); // r5 at 1 and 2 -> 1
        tbl[5]  = mk(1,0,0, 0,  5, 0, 2'b01,0, 2,0,2'b01,0,0); // non-writing r5 at 1
        tbl[6]  = mk(1,0,0, 0,  5, 0, 2'b01,0, 3,0,2'b01,0,0);
        tbl[7]  = mk(1,0,0, 0,  5, 0, 2'b01,0, 0,0,2'b00,0,0);
        tbl[8]  = mk(1,1,1, 7,  0, 0, 2'b00,0, 0,0,2'b00,0,0); // lw r7
        tbl[9]  = mk(1,1,0, 8,  7, 0, 2'b01,0, 1,0,2'b01,1,0); // load-use stall
        tbl[10] = mk(1,1,0, 8,  7, 0, 2'b01,0, 2,0,2'b01,0,1); // resolved from 2
        tbl[11] = mk(1,1,1, 7,  8, 0, 2'b01,0, 1,0,2'b01,0,1); // lw r7 reads r8
        tbl[12] = mk(1,0,0, 0,  7, 0, 2'b00,0, 0,0,2'b00,0,1); // r7 unused: no stall
        tbl[13] = mk(0,0,0, 0,  7, 0, 2'b01,0, 0,0,2'b00,0,1); // ex_valid=0 masks
        tbl[14] = mk(1,0,0, 0,  7, 0, 2'b01,0, 3,0,2'b01,0,1); // load at stage 3
        tbl[15] = mk(1,1,0,11,  0, 0, 2'b00,0, 0,0,2'b00,0,1); // alu r11
        tbl[16] = mk(1,1,1,11,  0, 0, 2'b00,0, 0,0,2'b00,0,1); // lw r11
        tbl[17] = mk(1,1,1,12,  0,11, 2'b11,0, 0,1,2'b10,1,1); // older alu match: still stall
        tbl[18] = mk(1,1,1,12,  0,11, 2'b11,0, 0,2,2'b10,0,2);
        tbl[19] = mk(1,1,0,12,  0, 0, 2'b00,0, 0,0,2'b00,0,2); // alu r12 over lw r12
        tbl[20] = mk(1,0,0, 0, 12, 0, 2'b01,0, 1,0,2'b01,0,2); // youngest is alu: no stall
        tbl[21] = mk(1,1,0, 0,  0, 0, 2'b00,0, 0,0,2'b00,0,2); // writes r0
        tbl[22] = mk(1,0,0, 0,  0, 0, 2'b11,0, 0,0,2'b00,0,2); // r0 at stage 1
        tbl[23] = mk(1,0,0, 0,  0, 0, 2'b11,0, 0,0,2'b00,0,2); // r0 at stage 2
        tbl[24] = mk(1,0,0, 0,  0, 0, 2'b11,0, 0,0,2'b00,0,2); // r0 at stage 3
        tbl[25] = mk(1,1,0, 9,  0, 0, 2'b00,1, 0,0,2'b00,0,2); // flushed r9
        tbl[26] = mk(1,0,0, 0,  9, 0, 2'b01,0, 0,0,2'b00,0,2);
        tbl[27] = mk(1,0,0, 0,  9, 0, 2'b01,0, 0,0,2'b00,0,2);
        tbl[28] = mk(1,1,1,13,  0, 0, 2'b00,0, 0,0,2'b00,0,2); // lw r13
        tbl[29] = mk(1,1,0,14, 13, 0, 2'b01,1, 1,0,2'b01,1,2); // stall + flush together
        tbl[30] = mk(1,1,0,14, 13, 0, 2'b01,0, 2,0,2'b01,0,3);

        rst_n = 1'b0;
        drive(0,0,0,5'd0,5'd0,5'd0,2'b00,0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1,1,0,5'd3,5'd3,5'd3,2'b11,0);
        @(negedge clk);
        chk("reset_sel",   32'(bus.fwd_sel),   32'd0);
        chk("reset_hit",   32'(bus.fwd_hit),   32'd0);
        chk("reset_stall", 32'(bus.stall_req), 32'd0);
        chk("reset_cnt",   32'(bus.stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        // Re-reset so the table starts from an empty pipeline.
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].l, tbl[i].rd, tbl[i].s0, tbl[i].s1,
                  tbl[i].used, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("v%0d_sel0", i),  32'(bus.fwd_sel[1:0]), 32'(tbl[i].e_sel0));
            chk($sformatf("v%0d_sel1", i),  32'(bus.fwd_sel[3:2]), 32'(tbl[i].e_sel1));
            chk($sformatf("v%0d_hit", i),   32'(bus.fwd_hit),      32'(tbl[i].e_hit));
            chk($sformatf("v%0d_stall", i), 32'(bus.stall_req),    32'(tbl[i].e_stall));
            chk($sformatf("v%0d_cnt", i),   32'(bus.stall_cnt),    32'(tbl[i].e_cnt));
            @(posedge clk);
            #1;
        end

        // Saturation: "lw r7 reading r7" held steady stalls every other cycle.
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        nstall = 0;
        e1_ld  = 1'b0;
        drive(1,1,1,5'd7,5'd7,5'd0,2'b01,0);
        for (int c = 0; c < 40; c++) begin
            exp_cnt = (nstall > 15) ? 4'd15 : 4'(nstall);
            @(negedge clk);
            chk($sformatf("sat%0d_stall", c), 32'(bus.stall_req), 32'(e1_ld));
            chk($sformatf("sat%0d_cnt", c),   32'(bus.stall_cnt), 32'(exp_cnt));
            if (e1_ld) nstall++;
            e1_ld = ~e1_ld;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("sat_final_cnt", 32'(bus.stall_cnt), 32'd15);
        chk("sat_c40_stall", 32'(bus.stall_req), 32'd0);
        @(posedge clk);
        #1;

        // Reset asserted on a stalling edge clears everything.
        @(negedge clk);
        chk("pre_rst_stall", 32'(bus.stall_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cnt",   32'(bus.stall_cnt), 32'd0);
        chk("post_rst_hit",   32'(bus.fwd_hit),   32'd0);
        chk("post_rst_stall", 32'(bus.stall_req), 32'd0);
        chk("post_rst_sel",   32'(bus.fwd_sel),   32'd0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_tracker.md
Name: fwd_hazard_tracker

Overview:
- Parametrised successor to the two-operand, two-stage forwarding unit.
- Holds its own shift register of in-flight destination writes, DEPTH stages past EX, and picks the youngest matching producer stage for each of NUM_SRC EX-stage source operands.
- Also detects load-use hazards and raises a stall request.
- Keeps a saturating stall-cycle counter for performance monitoring.
- Sits beside the EX stage and drives the operand bypass muxes and the pipeline hold logic.

Parameters:
- NUM_SRC, 2, number of EX-stage source operands checked.
- AW, 5, register address width.
- DEPTH, 3, tracked stages after EX (1=EX/MEM, 2=MEM/WB, 3=WB-bypass latch); minimum 2.
- SW, 2, width of each forward select; must hold the value DEPTH.
- CW, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- ex_valid  in  1  EX holds a real instruction.
- ex_regwrite  in  1  EX instruction writes a register.
- ex_is_load  in  1  EX instruction is a load; result is ready only from stage 2.
- ex_rd  in  AW  EX instruction destination register.
- ex_src  in  NUM_SRC*AW  EX source addresses; operand i occupies bits [i*AW +: AW].
- ex_src_used  in  NUM_SRC  operand i is actually read.
- flush  in  1  squash the EX instruction.
- fwd_sel  out  NUM_SRC*SW  per-operand select; 0 = register file, k = stage k.
- fwd_hit  out  NUM_SRC  per-operand forward active.
- stall_req  out  1  hold IF/ID/EX this cycle.
- stall_cnt  out  CW  saturating count of stall cycles.

Behaviour:
- Shift register state: DEPTH entries, each {v, wr, ld, rd}.
- Reset: while rst_n=0 at a rising edge, all entries have v=0 and stall_cnt=0.
  - fwd_sel=0, fwd_hit=0 and stall_req=0 in the cycle after reset.
- Entry k is "live" when v=1, wr=1 and rd!=0.
  - Register 0 never matches, forwards or stalls.
- Forward select (combinational from state and ex_src):
  - For operand i with ex_src_used[i]=1 and ex_valid=1, k = lowest live stage whose rd equals src_i.
  - fwd_sel[i]=k and fwd_hit[i]=1.
  - Otherwise fwd_sel[i]=0 and fwd_hit[i]=0.
  - The youngest producer always wins.
- Load-use: stall_req=1 when some used operand's winning stage is k=1 and that entry has ld=1.
  - A lower-priority older match does not cancel the stall.
  - fwd_sel for that operand still reports 1; the consumer ignores it while stalled.
- Shift every clock: entry k+1 <= entry k, and the oldest entry is dropped.
- Entry 1 load rule:
  - Entry 1 <= bubble (v=0) when stall_req=1, flush=1 or ex_valid=0.
  - Otherwise entry 1 <= {1, ex_regwrite, ex_is_load, ex_rd}.
  - The stalled consumer stays in EX. Next cycle the load sits in stage 2 and the operand forwards from 2.
  - A load-use stall therefore lasts exactly 1 cycle.
- flush and stall_req in the same cycle: a bubble is pushed either way.
  - stall_req is still asserted and still counted. Pipeline control gives flush priority.
- stall_cnt increments by 1 on each clock edge where stall_req=1.
  - It saturates at all-ones and never wraps.
- Reset mid-stall: all state and the counter clear on that edge; no residual stall.
- Latency:
  - Forwarding and stall outputs respond combinationally, same cycle.
  - A producer becomes visible at stage 1 one clock after it is in EX.

Test Plan:
- Back-to-back ALU: add r3 in EX, then a consumer with src0=r3, src1=r4 -> fwd_sel0=1, fwd_hit0=1, fwd_sel1=0, stall_req=0.
- Priority: r5 written by the instructions now at stages 1 and 2 -> fwd_sel0=1; after one idle cycle (ex_valid=0) -> fwd_sel0=2; one cycle later -> 3; one cycle later -> 0.
- Load-use: lw r7 then a consumer using r7 -> stall_req=1 for exactly 1 cycle with stall_cnt 0->1; the next cycle fwd_sel=2 and stall_req=0. The same r7 with ex_src_used=0 -> no stall.
- r0: producer writes r0 and consumer reads r0 -> fwd_hit=0, stall_req=0 in every stage.
- Flush and bubbles: flush=1 with ex_rd=r9 -> a later r9 reader sees fwd_hit=0. ex_regwrite=0 producer -> no forward.
- Counter and reset: CW=4, force 17 stall cycles -> stall_cnt stays 15. Assert rst_n=0 during a stall -> the next cycle has stall_cnt=0, all fwd_hit=0 and stall_req=0.
